// File: rtl/control_sequencer.sv
// Hardwired Moore sequencer: fetch (T0-T2) then a class-specific execute path (T3-T7), one instruction at a time.
// Latency FETCH0->FETCH0: reg/imm/ldi 6, ld/st 8, br 7, nop 4; no backpressure, halts on halt opcode or stop.
module control_sequencer #(
  parameter logic [4:0] ADD_OP  = 5'b00011,
  parameter logic [4:0] HALT_OP = 5'b11011,
  parameter logic [4:0] NOP_OP  = 5'b11010
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [4:0]  ALU_op,
  output logic        Run
);

  typedef enum logic [4:0] {
    S_RESET, S_F0, S_F1, S_F2,
    S_A3, S_RR4, S_IM4, S_WB5,
    S_LA3, S_LA4, S_LD5, S_LD6, S_LD7, S_ST6, S_ST7,
    S_BR3, S_BR4, S_BR5, S_BR6T, S_BR6N,
    S_NOP3, S_HALT
  } state_t;

  state_t     state, nxt;
  logic [4:0] op_q;
  logic [4:0] opcode;
  logic       ir_unused;

  assign opcode    = IR[31:27];
  assign ir_unused = ^IR[26:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_RESET;
      op_q  <= 5'b0;
    end else begin
      state <= nxt;
      if (state == S_F2) op_q <= opcode;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_RESET: nxt = S_F0;
      S_F0:    nxt = S_F1;
      S_F1:    nxt = S_F2;
      S_F2: begin
        if (opcode == HALT_OP) nxt = S_HALT;
        else begin
          case (opcode)
            5'b00000, 5'b00001, 5'b00010:           nxt = S_LA3;
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b01100, 5'b01101, 5'b01110:           nxt = S_A3;
            5'b10010:                               nxt = S_BR3;
            default:                                nxt = S_NOP3;
          endcase
        end
      end
      // Immediate opcodes are the only A3 users with bit 3 set
      S_A3:   nxt = op_q[3] ? S_IM4 : S_RR4;
      S_RR4:  nxt = S_WB5;
      S_IM4:  nxt = S_WB5;
      S_WB5:  nxt = S_F0;
      S_LA3:  nxt = S_LA4;
      S_LA4:  nxt = (op_q == 5'b00001) ? S_WB5 : S_LD5;
      S_LD5:  nxt = (op_q == 5'b00010) ? S_ST6 : S_LD6;
      S_LD6:  nxt = S_LD7;
      S_LD7:  nxt = S_F0;
      S_ST6:  nxt = S_ST7;
      S_ST7:  nxt = S_F0;
      S_BR3:  nxt = S_BR4;
      S_BR4:  nxt = S_BR5;
      // Branch outcome folded into the T6 state so outputs stay a pure state decode
      S_BR5:  nxt = CON_FF ? S_BR6T : S_BR6N;
      S_BR6T: nxt = S_F0;
      S_BR6N: nxt = S_F0;
      S_NOP3: nxt = S_F0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_RESET;
    endcase
    if (nxt == S_F0 && stop) nxt = S_HALT;
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zlowout = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0;
    ALU_op = 5'b0;
    Run = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_F0:   begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_F1:   begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_F2:   begin MDRout = 1'b1; IRin = 1'b1; end
      S_A3:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
      S_RR4:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = op_q; end
      // addi/andi/ori sit 9 codes above add/and/or
      S_IM4:  begin Cout = 1'b1; Zin = 1'b1; ALU_op = op_q - 5'b01001; end
      S_WB5:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_LA3:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      S_LA4:  begin Cout = 1'b1; Zin = 1'b1; ALU_op = ADD_OP; end
      S_LD5:  begin Zlowout = 1'b1; MARin = 1'b1; end
      S_LD6:  begin Read = 1'b1; MDRin = 1'b1; end
      S_LD7:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_ST6:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      S_ST7:  begin Write = 1'b1; end
      S_BR3:  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
      S_BR4:  begin PCout = 1'b1; Yin = 1'b1; end
      S_BR5:  begin Cout = 1'b1; Zin = 1'b1; ALU_op = ADD_OP; end
      S_BR6T: begin Zlowout = 1'b1; PCin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected strobe vectors queued per instruction and compared
// one cycle at a time, plus a per-cycle one-hot check on register selects and bus drivers.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, stop, CON_FF;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, CONin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Run;
  logic [4:0] ALU_op;

  control_sequencer dut (
    .clock(clock), .clear(clear), .stop(stop), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Zlowout(Zlowout), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .ALU_op(ALU_op), .Run(Run)
  );

  always #5 clock = ~clock;

  localparam logic [25:0] M_COUT = 26'd1 << 0,  M_BAOUT = 26'd1 << 1,  M_ROUT = 26'd1 << 2;
  localparam logic [25:0] M_RIN  = 26'd1 << 3,  M_GRC   = 26'd1 << 4,  M_GRB  = 26'd1 << 5;
  localparam logic [25:0] M_GRA  = 26'd1 << 6,  M_CONIN = 26'd1 << 7,  M_ZLOW = 26'd1 << 8;
  localparam logic [25:0] M_ZIN  = 26'd1 << 9,  M_YIN   = 26'd1 << 10, M_IRIN = 26'd1 << 11;
  localparam logic [25:0] M_WRITE= 26'd1 << 12, M_READ  = 26'd1 << 13, M_MDROUT = 26'd1 << 14;
  localparam logic [25:0] M_MDRIN= 26'd1 << 15, M_MARIN = 26'd1 << 16, M_INCPC = 26'd1 << 17;
  localparam logic [25:0] M_PCIN = 26'd1 << 18, M_PCOUT = 26'd1 << 19, M_RUN = 26'd1 << 25;

  localparam logic [25:0] V_F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [25:0] V_F1 = M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN;
  localparam logic [25:0] V_F2 = M_RUN | M_MDROUT | M_IRIN;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_NOP = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [25:0] got;
  assign got = {Run, ALU_op, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
                Yin, Zin, Zlowout, CONin, Gra, Grb, Grc, Rin, Rout, BAout, Cout};

  int n_checks = 0;
  int n_fail = 0;
  logic [25:0] exp_q[$];

  function automatic logic [25:0] alu(input logic [4:0] a);
    return {1'b0, a, 20'b0};
  endfunction

  always @(negedge clock) begin
    n_checks++;
    if (!$onehot0({Gra, Grb, Grc})) begin
      n_fail++;
      $display("FAIL reg_select_onehot: got Gra/Grb/Grc=%b, required at most one high", {Gra, Grb, Grc});
    end
    n_checks++;
    if (!$onehot0({PCout, Zlowout, MDRout, Rout, BAout, Cout})) begin
      n_fail++;
      $display("FAIL bus_driver_onehot: got drivers=%b, required at most one high",
               {PCout, Zlowout, MDRout, Rout, BAout, Cout});
    end
  end

  task automatic push_instr(input logic [4:0] op, input logic con);
    logic [25:0] r;
    logic [4:0]  m;
    r = M_RUN;
    exp_q.push_back(V_F0);
    exp_q.push_back(V_F1);
    exp_q.push_back(V_F2);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        exp_q.push_back(r | M_GRB | M_ROUT | M_YIN);
        exp_q.push_back(r | M_GRC | M_ROUT | M_ZIN | alu(op));
        exp_q.push_back(r | M_ZLOW | M_GRA | M_RIN);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        m = (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00100 : 5'b00101;
        exp_q.push_back(r | M_GRB | M_ROUT | M_YIN);
        exp_q.push_back(r | M_COUT | M_ZIN | alu(m));
        exp_q.push_back(r | M_ZLOW | M_GRA | M_RIN);
      end
      5'b00001: begin
        exp_q.push_back(r | M_GRB | M_BAOUT | M_YIN);
        exp_q.push_back(r | M_COUT | M_ZIN | alu(OP_ADD));
        exp_q.push_back(r | M_ZLOW | M_GRA | M_RIN);
      end
      5'b00000, 5'b00010: begin
        exp_q.push_back(r | M_GRB | M_BAOUT | M_YIN);
        exp_q.push_back(r | M_COUT | M_ZIN | alu(OP_ADD));
        exp_q.push_back(r | M_ZLOW | M_MARIN);
        if (op == 5'b00000) begin
          exp_q.push_back(r | M_READ | M_MDRIN);
          exp_q.push_back(r | M_MDROUT | M_GRA | M_RIN);
        end else begin
          exp_q.push_back(r | M_GRA | M_ROUT | M_MDRIN);
          exp_q.push_back(r | M_WRITE);
        end
      end
      5'b10010: begin
        exp_q.push_back(r | M_GRA | M_ROUT | M_CONIN);
        exp_q.push_back(r | M_PCOUT | M_YIN);
        exp_q.push_back(r | M_COUT | M_ZIN | alu(OP_ADD));
        exp_q.push_back(con ? (r | M_ZLOW | M_PCIN) : r);
      end
      5'b11011: ;
      default: exp_q.push_back(r);
    endcase
  endtask

  task automatic step_check(input string name);
    logic [25:0] e;
    @(posedge clock);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", name, got, e);
      end
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 64;
    while (exp_q.size() > 0 && budget > 0) begin
      step_check(name);
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected cycles left undrained, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_instr(input string name, input logic [31:0] ir, input logic con);
    IR = ir;
    CON_FF = con;
    push_instr(ir[31:27], con);
    drain(name);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (got !== 26'b0) begin
      n_fail++;
      $display("FAIL %s: got %h required 0000000", name, got);
    end
  endtask

  task automatic clear_pulse();
    #2;
    clear = 1'b0;
    #1;
    check_zero("clear_async");
    @(posedge clock);
    #1;
    stop = 1'b0;
    clear = 1'b1;
  endtask

  task automatic test_reset();
    clear = 1'b0; stop = 1'b0; CON_FF = 1'b0; IR = {OP_NOP, 27'b0};
    #2;
    check_zero("reset_initial");
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b1;
    exp_q.push_back(V_F0);
    exp_q.push_back(V_F1);
    drain("reset_release_fetch");
    #3;
    clear = 1'b0;
    #1;
    check_zero("clear_mid_fetch1");
    repeat (3) begin
      @(posedge clock);
      #1;
      check_zero("clear_hold");
    end
    clear = 1'b1;
  endtask

  task automatic test_nop();
    run_instr("nop", {OP_NOP, 27'b0}, 1'b0);
    run_instr("undefined_as_nop", {5'b10101, 27'h123}, 1'b0);
  endtask

  task automatic test_regreg();
    logic [4:0] ops [3];
    ops = '{5'b00100, 5'b00101, 5'b00110};
    run_instr("add", {5'b00011, 4'b0001, 4'b0000, 4'b0100, 15'b0}, 1'b0);
    foreach (ops[i]) run_instr("regreg", {ops[i], 27'($urandom())}, 1'b0);
  endtask

  task automatic test_imm();
    logic [4:0] ops [3];
    ops = '{5'b01100, 5'b01101, 5'b01110};
    foreach (ops[i]) run_instr("immediate", {ops[i], 27'($urandom())}, 1'b0);
  endtask

  task automatic test_load_store();
    run_instr("ldi", {5'b00001, 27'($urandom())}, 1'b0);
    run_instr("ld", {5'b00000, 27'($urandom())}, 1'b0);
    run_instr("st", {5'b00010, 27'($urandom())}, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("br_not_taken", {5'b10010, 27'($urandom())}, 1'b0);
    run_instr("br_taken", {5'b10010, 27'($urandom())}, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_st", {5'b00010, 27'h0}, 1'b0);
    run_instr("b2b_ori", {5'b01110, 27'h0}, 1'b0);
    run_instr("b2b_br", {5'b10010, 27'h0}, 1'b1);
    run_instr("b2b_ld", {5'b00000, 27'h0}, 1'b0);
  endtask

  task automatic test_stop();
    IR = {5'b01100, 27'($urandom())};
    CON_FF = 1'b0;
    push_instr(5'b01100, 1'b0);
    step_check("stop_addi");
    stop = 1'b1;
    drain("stop_addi");
    repeat (3) exp_q.push_back(26'b0);
    drain("stop_halted");
    clear_pulse();
    run_instr("recover_after_stop", {OP_NOP, 27'b0}, 1'b0);
  endtask

  task automatic test_halt_op();
    IR = {OP_HALT, 27'b0};
    push_instr(OP_HALT, 1'b0);
    repeat (4) exp_q.push_back(26'b0);
    drain("halt_opcode");
    clear_pulse();
    run_instr("recover_after_halt", {5'b00011, 27'h0}, 1'b0);
    IR = {OP_HALT, 27'b0};
    push_instr(OP_HALT, 1'b0);
    step_check("halt_with_stop");
    stop = 1'b1;
    repeat (3) exp_q.push_back(26'b0);
    drain("halt_with_stop");
    clear_pulse();
    run_instr("recover_final", {OP_NOP, 27'b0}, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nop();
    test_regreg();
    test_imm();
    test_load_store();
    test_branch();
    test_back_to_back();
    test_stop();
    test_halt_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
